axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI4 responder that fronts a single-port synchronous SRAM macro and serves one outstanding transaction at a time, read or write. It sits at the slave side of the AXI bus, opposite the CPU-side master wrapper. It accepts INCR bursts of 1–16 beats, converts each beat into SRAM chip-enable, byte-write and address strobes, and returns R and B responses with the captured ID.

## Interface
Parameters:
- ID_W, 8: AXI ID width, slave side.
- ADDR_W, 32: AXI address width.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- SRAM_AW, 14: SRAM word-address width; SRAM word address = AXADDR[SRAM_AW+1:2].

Ports:
- ACLK  in  1  clock; one clock for the whole block.
- ARESETn  in  1  reset, asynchronous, active-low.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ID_W/ADDR_W/4/3/2/1  write address channel.
- AWREADY  out  1  write address ready.
- WDATA/WSTRB/WLAST/WVALID  in  DATA_W/DATA_W/8/1/1  write data channel.
- WREADY  out  1  write data ready.
- BID/BRESP/BVALID  out  ID_W/2/1  write response channel.
- BREADY  in  1  write response ready.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID_W/ADDR_W/4/3/2/1  read address channel.
- ARREADY  out  1  read address ready.
- RID/RDATA/RRESP/RLAST/RVALID  out  ID_W/DATA_W/2/1/1  read data channel.
- RREADY  in  1  read data ready.
- CEB  out  1  SRAM chip enable, active-low.
- WEB  out  DATA_W/8  SRAM byte write enables, active-low; all ones = read.
- A  out  SRAM_AW  SRAM word address.
- DI  out  DATA_W  SRAM write data.
- DO  in  DATA_W  SRAM read data, valid one cycle after a CEB-low read.

## Operation
- States: IDLE, RREQ, RDATA, WDATA, WRESP.
- IDLE: ARREADY=1 and AWREADY=1 together. Exactly one request is accepted per cycle. If both ARVALID and AWVALID are high, see Configuration.
- On acceptance, latch ID, LEN and the word address, and clear the beat counter. AR goes to RREQ; AW goes to WDATA.
- RREQ:
  - CEB=0, WEB=all ones, A=current address; lasts one cycle.
  - Next state RDATA; DO is captured into the RDATA register at entry to RDATA.
- RDATA:
  - RVALID=1, RID=latched ID, RRESP=OKAY.
  - RLAST=1 when beat counter equals LEN.
  - RDATA, RID and RLAST stay stable until RREADY.
  - On handshake: if last beat, go to IDLE; else increment address and counter, go to RREQ.
- WDATA:
  - WREADY=1.
  - On each WVALID&WREADY beat: CEB=0, WEB=~WSTRB, A=current address, DI=WDATA, all in the same cycle. Then increment address and counter.
  - On WLAST beat, go to WRESP.
  - If WLAST does not coincide with counter==LEN, set a mismatch flag. Termination is always on WLAST; no further SRAM writes after it.
- WRESP:
  - BVALID=1, BID=latched ID.
  - BRESP=SLVERR (2'b10) if mismatch, else OKAY (2'b00).
  - On BREADY, go to IDLE and clear the flag.
- Burst handling: AxBURST and AxSIZE are ignored; INCR of full words is always used.
- Address increment is modulo 2^SRAM_AW; it wraps to 0 at the top of SRAM.
- Outside the active cycles described above: CEB=1, WEB=all ones, A=0, DI=0.

## Timing
- Reset values (ARESETn low, asynchronous): state=IDLE, all VALID/READY/LAST outputs 0, BRESP=RRESP=0, RDATA=RID=BID=0, CEB=1, WEB=all ones, A=0, DI=0.
- Reset asserted mid-burst aborts immediately. SRAM strobes return to idle in the same cycle, without waiting for a clock edge.
- AWREADY and ARREADY are 1 on the first cycle after reset release.
- Read latency: AR handshake at edge T; CEB low during cycle T..T+1; RVALID high from edge T+2.
- Read throughput: one beat per 2 cycles with RREADY held high.
- Write: one beat per cycle with WVALID held high. BVALID is high from the edge after the WLAST handshake.
- Ready signals are state-decoded, never combinationally dependent on the same channel's VALID.
- A W beat arriving before the AW handshake is not accepted; WREADY=0 in IDLE.

## Configuration
- AXI_SLV_WR_PRIORITY_EN defined: on simultaneous AWVALID and ARVALID in IDLE, the write is accepted (AWREADY=1, ARREADY=0 in that cycle).
- AXI_SLV_WR_PRIORITY_EN undefined: the read is accepted (ARREADY=1, AWREADY=0 in that cycle).
- In both cases the losing request is accepted on the next return to IDLE.

## Test plan
- Single read: ARADDR=0x0000_0010, ARLEN=0, ARID=0x05, DO=0xDEADBEEF -> A=4, RVALID at T+2, RDATA=0xDEADBEEF, RID=0x05, RLAST=1, RRESP=0.
- 4-beat read with RREADY low for 3 cycles on beat 2 -> A=8,9,10,11; beat-2 RDATA stable while stalled; RLAST only on beat 4.
- Write burst: AWADDR=0x20, AWLEN=1, WSTRB=4'b0011 then 4'b1111 -> WEB=1100 at A=8, then WEB=0000 at A=9; BRESP=0; BID echoes AWID.
- Early WLAST with AWLEN=3, WLAST on beat 2 -> exactly 2 SRAM writes; BRESP=2'b10.
- Simultaneous AWVALID/ARVALID -> write first with the macro defined, read first without; the other is served next.
- Wrap: ARADDR=0xFFFC (A=0x3FFF), ARLEN=1 -> second beat at A=0. Separately, ARESETn low mid-burst -> all outputs at reset values, CEB=1.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 burst slave in front of a single-port synchronous SRAM, one transaction in flight.
// Build option: define AXI_SLV_WR_PRIORITY_EN to let AW win over AR when both arrive together.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 14
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [3:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_W-1:0]       ARID,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  CEB,
    output logic [DATA_W/8-1:0]   WEB,
    output logic [SRAM_AW-1:0]    A,
    output logic [DATA_W-1:0]     DI,
    input  logic [DATA_W-1:0]     DO
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_RREQ, S_RDATA, S_WDATA, S_WRESP} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_wait_q, rd_wait_d;
    logic                mismatch_q, mismatch_d;
    logic                idle;
    logic                ar_hs;
    logic                aw_hs;
    logic                last_beat;
    logic                unused_bits;

    // Readies are gated by reset so they read 0 while ARESETn is low.
    assign idle = (state_q == S_IDLE) && ARESETn;
`ifdef AXI_SLV_WR_PRIORITY_EN
    assign AWREADY = idle;
    assign ARREADY = idle && !AWVALID;
`else
    assign ARREADY = idle;
    assign AWREADY = idle && !ARVALID;
`endif
    assign ar_hs     = ARVALID && ARREADY;
    assign aw_hs     = AWVALID && AWREADY;
    assign last_beat = (cnt_q == len_q);

    assign RVALID = (state_q == S_RDATA);
    assign RLAST  = RVALID && last_beat;
    assign RDATA  = rdata_q;
    assign RID    = id_q;
    assign RRESP  = 2'b00;
    assign WREADY = (state_q == S_WDATA);
    assign BVALID = (state_q == S_WRESP);
    assign BID    = id_q;
    assign BRESP  = (BVALID && mismatch_q) ? 2'b10 : 2'b00;

    assign unused_bits = ^{AWSIZE, AWBURST, ARSIZE, ARBURST,
                           AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0],
                           ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0]};

    always_comb begin
        // NOTE: every _d and every SRAM strobe gets a default first, so no path can infer a latch.
        state_d    = state_q;
        id_d       = id_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        rd_wait_d  = rd_wait_q;
        mismatch_d = mismatch_q;
        CEB        = 1'b1;
        WEB        = '1;
        A          = '0;
        DI         = '0;

        case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    id_d      = ARID;
                    len_d     = ARLEN;
                    addr_d    = ARADDR[SRAM_AW+1:2];
                    cnt_d     = '0;
                    rd_wait_d = 1'b0;
                    state_d   = S_RREQ;
                end else if (aw_hs) begin
                    id_d       = AWID;
                    len_d      = AWLEN;
                    addr_d     = AWADDR[SRAM_AW+1:2];
                    cnt_d      = '0;
                    mismatch_d = 1'b0;
                    state_d    = S_WDATA;
                end
            end
            // Issue phase strobes the SRAM; wait phase lets DO settle before it is registered.
            S_RREQ: begin
                if (!rd_wait_q) begin
                    CEB       = 1'b0;
                    A         = addr_q;
                    rd_wait_d = 1'b1;
                end else begin
                    rdata_d   = DO;
                    rd_wait_d = 1'b0;
                    state_d   = S_RDATA;
                end
            end
            // The next beat's read is issued in the handshake cycle, giving one beat per two cycles.
            S_RDATA: begin
                if (RREADY) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d    = addr_q + SRAM_AW'(1);
                        cnt_d     = cnt_q + 4'd1;
                        CEB       = 1'b0;
                        A         = addr_d;
                        rd_wait_d = 1'b1;
                        state_d   = S_RREQ;
                    end
                end
            end
            S_WDATA: begin
                if (WVALID) begin
                    CEB    = 1'b0;
                    WEB    = ~WSTRB;
                    A      = addr_q;
                    DI     = WDATA;
                    addr_d = addr_q + SRAM_AW'(1);
                    cnt_d  = cnt_q + 4'd1;
                    if (WLAST != last_beat) mismatch_d = 1'b1;
                    if (WLAST) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (BREADY) begin
                    mismatch_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the read-data holding register is a single word, so it is reset like any other flop.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            rd_wait_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment; the combinational block uses blocking.
            state_q    <= state_d;
            id_q       <= id_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            rd_wait_q  <= rd_wait_d;
            mismatch_q <= mismatch_d;
        end
    end

    logic [STRB_W-1:0] unused_strb_w;
    assign unused_strb_w = '0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed plus randomized bench for axi_sram_slave with an SRAM model and a word-level reference memory.
module tb_axi_sram_slave;
    localparam int ID_W    = 8;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SRAM_AW = 14;
    localparam int DEPTH   = 1 << SRAM_AW;

    logic                ACLK = 1'b0;
    logic                ARESETn;
    logic [ID_W-1:0]     AWID, ARID, BID, RID;
    logic [ADDR_W-1:0]   AWADDR, ARADDR;
    logic [3:0]          AWLEN, ARLEN;
    logic [2:0]          AWSIZE, ARSIZE;
    logic [1:0]          AWBURST, ARBURST, BRESP, RRESP;
    logic                AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic                ARVALID, ARREADY, RLAST, RVALID, RREADY, CEB;
    logic [DATA_W-1:0]   WDATA, RDATA, DI, DO;
    logic [3:0]          WSTRB, WEB;
    logic [SRAM_AW-1:0]  A;

    axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    always #5 ACLK = ~ACLK;

    // SRAM macro model: registered read, byte-masked write, plus access logs.
    bit   [DATA_W-1:0]  mem [DEPTH];
    int                 wr_cnt = 0;
    int                 rd_cnt = 0;
    logic [SRAM_AW-1:0] rd_a [256];

    always @(posedge ACLK) begin
        if (!CEB) begin
            if (&WEB) begin
                DO <= mem[A];
                rd_a[rd_cnt % 256] <= A;
                rd_cnt <= rd_cnt + 1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    // Reference: the memory contents implied by every completed AXI write.
    bit   [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] wd [16];
    logic [3:0]        ws [16];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SRAM_AW-1:0] widx(input logic [31:0] addr, input int i);
        return SRAM_AW'((addr >> 2) + 32'(i));
    endfunction

    task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        @(negedge ACLK);
        n = 0;
        while (!ARREADY && n < 40) begin @(negedge ACLK); n++; end
        check("ar_ready", ARREADY, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        @(negedge ACLK);
        n = 0;
        while (!AWREADY && n < 40) begin @(negedge ACLK); n++; end
        check("aw_ready", AWREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    // Starts one time unit after the AR handshake edge.
    task automatic r_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int stall_beat);
        int n;
        int rd0;
        logic [31:0] exp;
        rd0 = rd_cnt;
        RREADY = (stall_beat == 0) ? 1'b0 : 1'b1;
        @(negedge ACLK);
        check("r_lat_ceb", CEB, 0);
        check("r_lat_web", WEB, 4'hF);
        check("r_lat_a", A, widx(addr, 0));
        check("r_lat_rvalid0", RVALID, 0);
        @(negedge ACLK);
        check("r_lat_rvalid1", RVALID, 0);
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge ACLK);
            n = 0;
            while (!RVALID && n < 10) begin @(negedge ACLK); n++; end
            check("r_valid", RVALID, 1);
            check("r_gap", n, (i == 0) ? 0 : 1);
            exp = ref_mem[widx(addr, i)];
            check("r_data", RDATA, exp);
            check("r_id", RID, id);
            check("r_last", RLAST, (i == int'(len)) ? 1 : 0);
            check("r_resp", RRESP, 0);
            if (i == stall_beat) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge ACLK);
                    check("r_stall_valid", RVALID, 1);
                    check("r_stall_data", RDATA, exp);
                    check("r_stall_last", RLAST, (i == int'(len)) ? 1 : 0);
                end
                @(posedge ACLK); #1;
                RREADY = 1'b1;
            end
            @(posedge ACLK); #1;
            if (i + 1 == stall_beat) RREADY = 1'b0;
        end
        RREADY = 1'b0;
        check("r_sram_reads", rd_cnt - rd0, int'(len) + 1);
        for (int k = 0; k <= int'(len); k++)
            check("r_sram_addr", rd_a[(rd0 + k) % 256], widx(addr, k));
    endtask

    // Starts one time unit after the AW handshake edge; beats come from wd/ws.
    task automatic w_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int nbeats);
        int w0;
        logic [3:0] exp_web;
        logic [SRAM_AW-1:0] w;
        w0 = wr_cnt;
        for (int j = 0; j < nbeats; j++) begin
            WVALID = 1'b1; WDATA = wd[j]; WSTRB = ws[j]; WLAST = (j == nbeats - 1);
            exp_web = ~ws[j];
            w = widx(addr, j);
            @(negedge ACLK);
            check("w_ready", WREADY, 1);
            check("w_ceb", CEB, 0);
            check("w_web", WEB, exp_web);
            check("w_a", A, w);
            check("w_di", DI, wd[j]);
            for (int b = 0; b < 4; b++)
                if (ws[j][b]) ref_mem[w][8*b +: 8] = wd[j][8*b +: 8];
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
        @(negedge ACLK);
        check("b_valid", BVALID, 1);
        check("b_id", BID, id);
        check("b_resp", BRESP, (nbeats == int'(len) + 1) ? 2'b00 : 2'b10);
        check("b_ceb_idle", CEB, 1);
        check("b_wready", WREADY, 0);
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        @(negedge ACLK);
        check("b_valid_hold", BVALID, 1);
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        check("b_valid_drop", BVALID, 0);
        check("w_sram_writes", wr_cnt - w0, nbeats);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [3:0]  rl;
        logic [7:0]  rid;
        int          w0;
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        // Reset values, then readies on the first cycle after release.
        #12;
        check("rst_ceb", CEB, 1);
        check("rst_web", WEB, 4'hF);
        check("rst_a", A, 0);
        check("rst_di", DI, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_awready", AWREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rid_bid", {RID, BID}, 0);
        #10 ARESETn = 1'b1;
        #1;
        check("rel_arready", ARREADY, 1);
        check("rel_awready", AWREADY, 1);
        @(posedge ACLK); #1;

        // W beat before AW is refused.
        w0 = wr_cnt;
        WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF; WLAST = 1'b1;
        repeat (2) begin
            @(negedge ACLK);
            check("idle_wready", WREADY, 0);
            check("idle_ceb", CEB, 1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("idle_no_write", wr_cnt - w0, 0);

        // Single read of 0xDEADBEEF at word 4.
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        aw_phase(8'h11, 32'h0000_0010, 4'd0);
        w_phase(8'h11, 32'h0000_0010, 4'd0, 1);
        ar_phase(8'h05, 32'h0000_0010, 4'd0);
        r_phase(8'h05, 32'h0000_0010, 4'd0, 99);

        // Two-beat write with partial then full strobes.
        wd[0] = 32'hA1B2_C3D4; ws[0] = 4'b0011;
        wd[1] = 32'h5566_7788; ws[1] = 4'b1111;
        aw_phase(8'h3C, 32'h0000_0020, 4'd1);
        w_phase(8'h3C, 32'h0000_0020, 4'd1, 2);

        // Fill words 10,11 then read 8..11 with beat 2 stalled.
        wd[0] = $urandom; ws[0] = 4'hF;
        wd[1] = $urandom; ws[1] = 4'hF;
        aw_phase(8'h3D, 32'h0000_0028, 4'd1);
        w_phase(8'h3D, 32'h0000_0028, 4'd1, 2);
        ar_phase(8'h9A, 32'h0000_0020, 4'd3);
        r_phase(8'h9A, 32'h0000_0020, 4'd3, 1);

        // Early WLAST: AWLEN=3 but WLAST on the second beat.
        wd[0] = $urandom; ws[0] = 4'hF;
        wd[1] = $urandom; ws[1] = 4'hF;
        aw_phase(8'h4E, 32'h0000_0200, 4'd3);
        w_phase(8'h4E, 32'h0000_0200, 4'd3, 2);

        // Wrap at the top of the SRAM.
        wd[0] = $urandom; ws[0] = 4'hF;
        wd[1] = $urandom; ws[1] = 4'hF;
        aw_phase(8'h60, 32'h0000_FFFC, 4'd1);
        w_phase(8'h60, 32'h0000_FFFC, 4'd1, 2);
        ar_phase(8'h61, 32'h0000_FFFC, 4'd1);
        r_phase(8'h61, 32'h0000_FFFC, 4'd1, 99);

        // Simultaneous AW and AR; the loser is served next.
        wd[0] = $urandom; ws[0] = 4'hF;
        ARID = 8'h31; ARADDR = 32'h0000_0020; ARLEN = 4'd1; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        AWID = 8'h42; AWADDR = 32'h0000_0800; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        @(negedge ACLK);
`ifdef AXI_SLV_WR_PRIORITY_EN
        check("sim_awready", AWREADY, 1);
        check("sim_arready", ARREADY, 0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        w_phase(8'h42, 32'h0000_0800, 4'd0, 1);
        ar_phase(8'h31, 32'h0000_0020, 4'd1);
        r_phase(8'h31, 32'h0000_0020, 4'd1, 99);
`else
        check("sim_arready", ARREADY, 1);
        check("sim_awready", AWREADY, 0);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        r_phase(8'h31, 32'h0000_0020, 4'd1, 99);
        aw_phase(8'h42, 32'h0000_0800, 4'd0);
        w_phase(8'h42, 32'h0000_0800, 4'd0, 1);
`endif

        // Randomized mix of reads and writes over a small window with random upper address bits.
        for (int t = 0; t < 24; t++) begin
            ra  = ($urandom & 32'hFFFF_0000) | 32'h0000_0400 | (32'($urandom_range(0, 63)) << 2);
            rl  = 4'($urandom_range(0, 15));
            rid = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int j = 0; j < 16; j++) begin
                    wd[j] = $urandom;
                    ws[j] = 4'($urandom_range(1, 15));
                end
                aw_phase(rid, ra, rl);
                w_phase(rid, ra, rl, int'(rl) + 1);
            end else begin
                ar_phase(rid, ra, rl);
                r_phase(rid, ra, rl, $urandom_range(0, 20));
            end
        end

        // Reset in the middle of a write beat drops the SRAM strobes at once.
        aw_phase(8'h77, 32'h0000_0100, 4'd3);
        w0 = wr_cnt;
        WVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WLAST = 1'b0;
        @(negedge ACLK);
        check("mid_ceb_active", CEB, 0);
        #2 ARESETn = 1'b0;
        #1;
        check("mid_rst_ceb", CEB, 1);
        check("mid_rst_web", WEB, 4'hF);
        check("mid_rst_a", A, 0);
        check("mid_rst_di", DI, 0);
        check("mid_rst_wready", WREADY, 0);
        check("mid_rst_readies", {ARREADY, AWREADY}, 0);
        check("mid_rst_valids", {RVALID, BVALID, RLAST}, 0);
        check("mid_rst_rdata", RDATA, 0);
        check("mid_rst_ids", {RID, BID}, 0);
        check("mid_rst_resp", {RRESP, BRESP}, 0);
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        @(negedge ACLK);
        #2 ARESETn = 1'b1;
        #1;
        check("mid_rel_readies", {ARREADY, AWREADY}, 2'b11);
        check("mid_no_write", wr_cnt - w0, 0);
        @(posedge ACLK); #1;

        ar_phase(8'h88, 32'h0000_0020, 4'd3);
        r_phase(8'h88, 32'h0000_0020, 4'd3, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
